// File: rtl/fnormalize_pipe.sv
// fnormalize_pipe
// Pipelined floating-point normaliser. Left-shifts an unnormalised mantissa
// until its MSB is set, but never below the minimum normal exponent of the
// selected format (the denormal floor). The exponent is adjusted to match.
// The pipeline has three stages, is stalled by i_clkEn and has no
// backpressure.
//
// Optional feature macro: FNORM_GUARD_EN. When it is defined, two guard bits
// travel below the mantissa and shift into its LSBs.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset (takes effect regardless of i_clkEn)
//   i_clkEn      pipeline advance enable; 0 freezes every register
//   i_en         input valid, sampled only when i_clkEn=1
//   i_fmt        0 single, 1 double, 2/3 extended
//   i_a_mant     unsigned input mantissa
//   i_a_exp      unified biased exponent
//   i_a_grd      guard bits below the mantissa (FNORM_GUARD_EN only)
//   o_res_valid  result valid, three enabled cycles after the input
//   o_res_mant   normalised mantissa
//   o_res_exp    adjusted exponent
//   o_res_den    result is denormal (MSB clear, not zero)
//   o_res_zero   input mantissa was zero
//   o_res_grd    remaining guard bits (FNORM_GUARD_EN only)
module fnormalize_pipe #(
  parameter int MANT_W = 64,
  parameter int EXP_W  = 16,
  parameter logic [EXP_W-1:0] MIN_SGL = EXP_W'(16'h3F81),
  parameter logic [EXP_W-1:0] MIN_DBL = EXP_W'(16'h3C01),
  parameter logic [EXP_W-1:0] MIN_EXT = EXP_W'(16'h0001)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clkEn,
  input  logic              i_en,
  input  logic [1:0]        i_fmt,
  input  logic [MANT_W-1:0] i_a_mant,
  input  logic [EXP_W-1:0]  i_a_exp,
`ifdef FNORM_GUARD_EN
  input  logic [1:0]        i_a_grd,
  output logic [1:0]        o_res_grd,
`endif
  output logic              o_res_valid,
  output logic [MANT_W-1:0] o_res_mant,
  output logic [EXP_W-1:0]  o_res_exp,
  output logic              o_res_den,
  output logic              o_res_zero
);

  localparam int SHW = $clog2(MANT_W);
  localparam int LZW = SHW + 1;
`ifdef FNORM_GUARD_EN
  localparam int GW = 2;
`else
  localparam int GW = 0;
`endif
  localparam int DW = MANT_W + GW;

  // The shifted datapath carries the guard bits (if present) below the mantissa
  logic [DW-1:0] w_inData;
`ifdef FNORM_GUARD_EN
  assign w_inData = {i_a_mant, i_a_grd};
`else
  assign w_inData = i_a_mant;
`endif

  // Leading-zero count over the mantissa only; the ascending loop lets the
  // highest set bit win. An all-zero mantissa yields MANT_W.
  logic [LZW-1:0] w_lzc;
  always_comb begin
    w_lzc = LZW'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (i_a_mant[i]) w_lzc = LZW'(MANT_W - 1 - i);
    end
  end

  // Shift headroom above the format's floor, one bit wider so a negative
  // difference (input already below the floor) can be detected and clamped
  logic [EXP_W-1:0] w_minFmt;
  logic [EXP_W:0]   w_limWide;
  logic [EXP_W-1:0] w_lim;
  always_comb begin
    case (i_fmt)
      2'd0:    w_minFmt = MIN_SGL;
      2'd1:    w_minFmt = MIN_DBL;
      default: w_minFmt = MIN_EXT;
    endcase
    w_limWide = {1'b0, i_a_exp} - {1'b0, w_minFmt};
    w_lim     = w_limWide[EXP_W] ? '0 : w_limWide[EXP_W-1:0];
  end

  logic [DW-1:0]    r1_data;
  logic [EXP_W-1:0] r1_exp;
  logic [LZW-1:0]   r1_lzc;
  logic [EXP_W-1:0] r1_lim;
  logic             r1_zero;

  // The shift is limited by the floor. A zero mantissa is never shifted.
  // Saturating at MANT_W-1 keeps the amount inside the shifter range.
  logic [EXP_W-1:0] w_lzcExt;
  logic [EXP_W-1:0] w_shFull;
  logic [SHW-1:0]   w_sh;
  logic [DW-1:0]    w_coarse;
  always_comb begin
    w_lzcExt = EXP_W'(r1_lzc);
    w_shFull = (w_lzcExt < r1_lim) ? w_lzcExt : r1_lim;
    if (r1_zero)
      w_sh = '0;
    else if (w_shFull > EXP_W'(MANT_W - 1))
      w_sh = SHW'(MANT_W - 1);
    else
      w_sh = w_shFull[SHW-1:0];
    w_coarse = r1_data << {w_sh[SHW-1:3], 3'b000};
  end

  logic [DW-1:0]    r2_data;
  logic [EXP_W-1:0] r2_exp;
  logic [SHW-1:0]   r2_sh;
  logic             r2_zero;

  // The fine shift by the low three bits completes the normalisation
  logic [DW-1:0]    w_fine;
  logic [EXP_W-1:0] w_expAdj;
  always_comb begin
    w_fine   = r2_data << r2_sh[2:0];
    w_expAdj = r2_exp - EXP_W'(r2_sh);
  end

  // Datapath registers. The contents of bubbles do not matter, so these
  // registers have no reset and only follow i_clkEn.
  always_ff @(posedge i_clk) begin
    if (i_clkEn) begin
      r1_data <= w_inData;
      r1_exp  <= i_a_exp;
      r1_lzc  <= w_lzc;
      r1_lim  <= w_lim;
      r1_zero <= (w_lzc == LZW'(MANT_W));
      r2_data <= w_coarse;
      r2_exp  <= r1_exp;
      r2_sh   <= w_sh;
      r2_zero <= r1_zero;
    end
  end

  logic             r_v1, r_v2, r_v3;
  logic [DW-1:0]    r_resData;
  logic [EXP_W-1:0] r_resExp;
  logic             r_resDen;
  logic             r_resZero;

  // Valid tracking and output registers. Reset takes priority over i_clkEn
  // and over a new input. A bubble drives all outputs to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_resData <= '0;
      r_resExp  <= '0;
      r_resDen  <= 1'b0;
      r_resZero <= 1'b0;
    end else if (i_clkEn) begin
      r_v1 <= i_en;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (r_v2) begin
        r_resData <= w_fine;
        r_resExp  <= r2_zero ? '0 : w_expAdj;
        r_resDen  <= ~w_fine[DW-1] & ~r2_zero;
        r_resZero <= r2_zero;
      end else begin
        r_resData <= '0;
        r_resExp  <= '0;
        r_resDen  <= 1'b0;
        r_resZero <= 1'b0;
      end
    end
  end

  assign o_res_valid = r_v3;
  assign o_res_mant  = r_resData[DW-1 -: MANT_W];
  assign o_res_exp   = r_resExp;
  assign o_res_den   = r_resDen;
  assign o_res_zero  = r_resZero;
`ifdef FNORM_GUARD_EN
  assign o_res_grd   = r_resData[1:0];
`endif

endmodule
